// File: rtl/intrapred_mode_decider.sv
// intrapred_mode_decider
//   Streaming intra-prediction mode decision. Accumulates per-mode SAD over
//   one BLK_W x BLK_H block delivered LANES pixels per beat. It then walks
//   the modes one per cycle and keeps the lowest-SAD enabled mode. Ties keep
//   the lowest index. The winner is returned over a valid/ready handshake.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   in_orig             LANES original pixels, lane 0 in LSBs
//   in_pred             NUM_MODES x LANES predicted pixels, mode m at m*LANES*PIX_BITS
//   in_last             producer's end-of-block marker (checked, not obeyed)
//   mode_mask           per-mode enable, sampled on the first beat of a block
//   out_valid/out_ready result handshake
//   out_mode, out_sad   winning mode index and its SAD
//   out_none            no mode was enabled
//   out_err             in_last disagreed with the internal beat count
//
// state   | meaning
// --------+------------------------------------------------------------
// ACCUM   | accepting beats, accumulating SAD for every mode
// SELECT  | scanning mode k = 0..NUM_MODES-1, one per cycle
// OUTPUT  | result presented, waiting for out_ready

module intrapred_mode_decider #(
    parameter int PIX_BITS  = 8,
    parameter int NUM_MODES = 9,
    parameter int BLK_W     = 4,
    parameter int BLK_H     = 4,
    parameter int LANES     = 4,
    localparam int MODE_BITS = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int SAD_BITS  = PIX_BITS + $clog2(BLK_W * BLK_H)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*PIX_BITS-1:0]            in_orig,
    input  logic [NUM_MODES*LANES*PIX_BITS-1:0]  in_pred,
    input  logic                                 in_last,
    input  logic [NUM_MODES-1:0]                 mode_mask,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [MODE_BITS-1:0]                 out_mode,
    output logic [SAD_BITS-1:0]                  out_sad,
    output logic                                 out_none,
    output logic                                 out_err
);

    localparam int PIX_CNT  = BLK_W * BLK_H;
    localparam int BEATS    = PIX_CNT / LANES;
    localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((PIX_CNT % LANES) != 0) begin : g_bad_lanes
        $error("intrapred_mode_decider: BLK_W*BLK_H must be a multiple of LANES");
    end

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_SELECT = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [SAD_BITS-1:0]    acc_q [NUM_MODES];
    logic [SAD_BITS-1:0]    acc_d [NUM_MODES];
    logic [SAD_BITS-1:0]    beat_sad [NUM_MODES];
    logic [NUM_MODES-1:0]   mask_q, mask_d;
    logic                   err_q, err_d;
    logic [MODE_BITS-1:0]   sel_q, sel_d;
    logic                   best_valid_q, best_valid_d;
    logic [MODE_BITS-1:0]   best_mode_q, best_mode_d;
    logic [SAD_BITS-1:0]    best_sad_q, best_sad_d;

    logic first_beat;
    logic last_beat;

    // Operands widened by one bit so the subtraction never wraps.
    function automatic logic [PIX_BITS:0] abs_diff(input logic [PIX_BITS-1:0] a,
                                                   input logic [PIX_BITS-1:0] b);
        logic [PIX_BITS:0] ax;
        logic [PIX_BITS:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        return (ax >= bx) ? (ax - bx) : (bx - ax);
    endfunction

    always_comb begin
        for (int m = 0; m < NUM_MODES; m++) begin
            beat_sad[m] = '0;
            for (int l = 0; l < LANES; l++) begin
                beat_sad[m] = beat_sad[m] + SAD_BITS'(abs_diff(
                    in_orig[l*PIX_BITS +: PIX_BITS],
                    in_pred[(m*LANES + l)*PIX_BITS +: PIX_BITS]));
            end
        end
    end

    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == CNT_BITS'(BEATS - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mask_d       = mask_q;
        err_d        = err_q;
        sel_d        = sel_q;
        best_valid_d = best_valid_q;
        best_mode_d  = best_mode_q;
        best_sad_d   = best_sad_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_mode     = '0;
        out_sad      = '0;
        out_none     = 1'b0;
        out_err      = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // First beat overwrites so no separate clear cycle is needed.
                    for (int m = 0; m < NUM_MODES; m++) begin
                        acc_d[m] = first_beat ? beat_sad[m] : (acc_q[m] + beat_sad[m]);
                    end
                    if (first_beat) begin
                        mask_d = mode_mask;
                    end
                    if (in_last != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        cnt_d        = '0;
                        sel_d        = '0;
                        best_valid_d = 1'b0;
                        best_mode_d  = '0;
                        best_sad_d   = '1;
                        state_d      = ST_SELECT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_SELECT: begin
                // Strict less-than keeps the earliest (lowest-index) mode on ties.
                if (mask_q[sel_q] && (!best_valid_q || (acc_q[sel_q] < best_sad_q))) begin
                    best_valid_d = 1'b1;
                    best_mode_d  = sel_q;
                    best_sad_d   = acc_q[sel_q];
                end
                if (sel_q == MODE_BITS'(NUM_MODES - 1)) begin
                    state_d = ST_OUTPUT;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end

            ST_OUTPUT: begin
                out_valid = 1'b1;
                out_none  = ~best_valid_q;
                out_mode  = best_valid_q ? best_mode_q : '0;
                out_sad   = best_valid_q ? best_sad_q  : '1;
                out_err   = err_q;
                if (out_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ACCUM;
            cnt_q        <= '0;
            for (int m = 0; m < NUM_MODES; m++) begin
                acc_q[m] <= '0;
            end
            mask_q       <= '0;
            err_q        <= 1'b0;
            sel_q        <= '0;
            best_valid_q <= 1'b0;
            best_mode_q  <= '0;
            best_sad_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
            sel_q        <= sel_d;
            best_valid_q <= best_valid_d;
            best_mode_q  <= best_mode_d;
            best_sad_q   <= best_sad_d;
        end
    end

endmodule

// File: doc/intrapred_mode_decider.md
Name: intrapred_mode_decider

Overview:
- Parametrised, streaming successor to the fixed-size intra prediction top. It accepts original pixels plus candidate predictions for N modes, LANES pixels per beat.
- It accumulates per-mode SAD over one block, then serially selects the minimum-SAD enabled mode.
- It returns the winning mode and SAD over a valid/ready handshake.
- It serves luma 4x4, luma 16x16 and chroma 8x8 decisions with one design, replacing the per-size sader/saver pairs.

Parameters:
- PIX_BITS, 8, bits per pixel sample.
- NUM_MODES, 9, number of candidate prediction modes (>=1).
- BLK_W, 4, block width in pixels.
- BLK_H, 4, block height in pixels.
- LANES, 4, pixels per input beat. BLK_W*BLK_H must be a multiple of LANES; elaboration error otherwise.
- MODE_BITS, derived = max(1, clog2(NUM_MODES)), mode index width.
- SAD_BITS, derived = PIX_BITS + clog2(BLK_W*BLK_H), SAD width; no overflow possible.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  block can accept a beat.
- in_orig  in  LANES*PIX_BITS  original pixels, lane 0 in LSBs, raster order.
- in_pred  in  NUM_MODES*LANES*PIX_BITS  predictions; mode m occupies slice m*LANES*PIX_BITS upward, same lane order.
- in_last  in  1  producer marks final beat of block.
- mode_mask  in  NUM_MODES  bit m=1 enables mode m; sampled on first beat of each block only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_mode  out  MODE_BITS  winning mode index.
- out_sad  out  SAD_BITS  winning SAD.
- out_none  out  1  no mode enabled in sampled mask.
- out_err  out  1  in_last disagreed with internal beat count during this block.

Behaviour:
- BEATS = BLK_W*BLK_H/LANES. States: ACCUM, SELECT, OUTPUT. Reset enters ACCUM.
- Reset values: in_ready=1, out_valid=0, out_mode=0, out_sad=0, out_none=0, out_err=0. Also cleared: beat counter, accumulators, error latch, mask register.
- Reset mid-block or mid-output aborts everything; no partial result is ever emitted.

ACCUM:
- in_ready=1.
- Each accepted beat (in_valid & in_ready) adds sum over lanes of |orig-pred| to acc[m] for every mode m. Absolute difference is computed unsigned at PIX_BITS+1 bits.
- The first beat (count 0) loads acc[m] rather than adding, and latches mode_mask.
- Beat counter wraps at BEATS-1. On that beat, go to SELECT.
- in_last on a beat other than BEATS-1, or absent on beat BEATS-1, sets the error latch. in_last does not terminate the block early; the count alone defines block end.
- No accepted beat means no state change. in_valid low holds everything.

SELECT:
- in_ready=0. Runs exactly NUM_MODES cycles, examining mode k = 0..NUM_MODES-1 one per cycle.
- best starts invalid. Mode k replaces best if mask[k]=1 and (best invalid or acc[k] < best_sad). Strict less-than means ties keep the lowest index.
- After mode NUM_MODES-1, go to OUTPUT.

OUTPUT:
- out_valid=1, with out_mode/out_sad/out_none/out_err held stable until out_valid & out_ready.
- If no mode is enabled: out_none=1, out_mode=0, out_sad=all ones.
- On handshake: out_valid=0 next cycle, error latch cleared, return to ACCUM with in_ready=1.
- No bypass: a new block cannot start in the handshake cycle.

Latency and throughput:
- Latency from the final beat accepted to out_valid=1 is NUM_MODES+1 cycles.
- Throughput is one block per BEATS+NUM_MODES+1 cycles when out_ready is held high.

Test Plan:
- Default params. Orig all 100. Mode 3 pred all 100; other modes pred all 110; mask all ones, 4 beats, in_last on beat 3 -> out_mode=3, out_sad=0, out_err=0, out_none=0. out_valid rises 10 cycles after the final beat.
- Modes 2 and 5 both give SAD 16, all others 160 -> out_mode=2, out_sad=16 (tie goes to lowest index).
- Same data as the first test but mask=9'h1F7 (mode 3 disabled), mode 7 pred 101 -> out_mode=7, out_sad=16. A mask change on beat 2 must have no effect.
- Orig 0, all preds 255, mask all ones -> out_sad=4080, no overflow. mask=0 -> out_none=1, out_sad=all ones (SAD_BITS=12).
- in_last on beat 1 and again on beat 3 -> result still produced after 4 beats with out_err=1. Next clean block -> out_err=0.
- Hold out_ready=0 for 20 cycles -> outputs stable, in_ready=0. Then release -> one handshake only. Separately, assert reset during beat 2 -> after reset no out_valid, and the next full block gives the correct result.
- Params BLK_W=BLK_H=16, LANES=16, NUM_MODES=4 -> 16 beats, out_valid 5 cycles after the last beat, correct minimum reported.
